match_logger: RTL

Downstream stage of the byte-pattern matcher. Samples the matcher's 32-bit `Found` result every clock and, on a non-zero value, computes the match length in bytes. Pushes {length, word} into a small FIFO drained by the host through a valid/ready port. Also keeps saturating match and drop statistics and a sticky overflow flag for the test controller.

---
 rtl/match_log_pkg.sv | 25 ++
 rtl/match_log_fifo.sv | 72 +++++++
 rtl/match_logger.sv | 102 ++++++++++
 3 files changed

// File: rtl/match_log_pkg.sv
// Shared types and helpers for the match logger: FIFO entry layout and match-length decode.
package match_log_pkg;

    localparam int DATA_W     = 32;
    localparam int LEN_W      = 3;
    localparam int LOG_DROP_W = 8;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [DATA_W-1:0] word;
    } match_entry_t;

    // Length is the position of the most significant non-zero byte.
    function automatic logic [LEN_W-1:0] match_len(input logic [DATA_W-1:0] word);
        if (word[31:24] != 8'h00) begin
            return 3'd4;
        end else if (word[23:16] != 8'h00) begin
            return 3'd3;
        end else if (word[15:8] != 8'h00) begin
            return 3'd2;
        end
        return 3'd1;
    endfunction

endpackage

// File: rtl/match_log_fifo.sv
// Show-ahead FIFO of match entries; head is read combinationally from storage, zero when empty.
module match_log_fifo
    import match_log_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  match_entry_t             wr_entry,
    output match_entry_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    match_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Extra pointer MSB separates the full and empty cases once the pointers wrap.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + PW'(1);
            end else if (do_pop && !do_push) begin
                level <= level - PW'(1);
            end
        end
    end

    // Storage carries data only and is never reset; a full-with-pop push reuses the slot being freed.
    always_ff @(posedge clock) begin
        if (do_push && !clr) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

    always_comb begin
        head = '0;
        if (!empty) begin
            head = mem[rd_ptr[AW-1:0]];
        end
    end

endmodule

// File: rtl/match_logger.sv
// Captures non-zero matcher results into a FIFO with match/drop statistics.
// Optional MATCH_LOG_DEDUP_EN discards captures equal to the last accepted word.
module match_logger
    import match_log_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [DATA_W-1:0]       Found,
    input  logic                    clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_word,
    output logic [LEN_W-1:0]        out_len,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_W-1:0]        match_count,
    output logic [LOG_DROP_W-1:0]   drop_count,
    output logic                    overflow
);

    function automatic logic [CNT_W-1:0] sat_inc_match(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [LOG_DROP_W-1:0] sat_inc_drop(input logic [LOG_DROP_W-1:0] v);
        return (&v) ? v : v + LOG_DROP_W'(1);
    endfunction

    logic         cap;
    logic         push;
    logic         pop;
    logic         drop;
    logic         full;
    logic         empty;
    match_entry_t wr_entry;
    match_entry_t head;

`ifdef MATCH_LOG_DEDUP_EN
    logic [DATA_W-1:0] last_word;

    // Zero never equals a real capture, so the cleared register cannot suppress one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_word <= '0;
        end else if (clr) begin
            last_word <= '0;
        end else if (push) begin
            last_word <= Found;
        end
    end

    assign cap = (Found != '0) && (Found != last_word);
`else
    assign cap = (Found != '0);
`endif

    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign push      = cap & (~full | pop);
    assign drop      = cap & full & ~pop;
    assign wr_entry  = '{len: match_len(Found), word: Found};
    assign out_word  = head.word;
    assign out_len   = head.len;

    match_log_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr      (clr),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .level    (level)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            match_count <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
        end else if (clr) begin
            match_count <= '0;
            drop_count  <= '0;
            overflow    <= 1'b0;
        end else begin
            if (push) begin
                match_count <= sat_inc_match(match_count);
            end
            if (drop) begin
                drop_count <= sat_inc_drop(drop_count);
                overflow   <= 1'b1;
            end
        end
    end

endmodule
